nios_led2_switch_ctrl: RTL and testbench
========================================

// Module: nios_led2_switch_ctrl
// PURPOSE
//  Avalon-MM controller for the board slide-switch inputs feeding the Nios II CPU.
//  Synchronises and debounces WIDTH raw switch lines and detects edges on them.
//  Latches edges into a write-1-to-clear capture register and raises a maskable irq.
//  Replaces the plain input PIO on the switch bus; same 4-word register map.
// PARAMETERS
//  WIDTH         10     number of switch lines
//  TICK_DIV      50000  clk cycles per debounce sample tick (1 ms @ 50 MHz); >=2
//  STABLE_TICKS  8      consecutive ticks a new level must hold before it is accepted; 1..255
//  EDGE_TYPE     2      0 = rising only, 1 = falling only, 2 = any edge
// PORTS
//  clk         in   1      system clock, single clock domain
//  reset       in   1      synchronous, active-high reset
//  address     in   2      Avalon word address
//  chipselect  in   1      Avalon select
//  write_n     in   1      Avalon write strobe, active-low
//  writedata   in   32     Avalon write data
//  readdata    out  32     Avalon read data, registered
//  in_port     in   WIDTH  raw asynchronous switch levels
//  irq         out  1      level interrupt to the CPU, active-high
// BEHAVIOUR
//  Reset: readdata=0, irq=0, irqmask=0, edgecapture=0, sync/stable=0, prescaler=0, FSM=S_SYNC.
//  Register map (word address):
//   0 DATA  RO  {0, stable[WIDTH-1:0]}
//   1 RSVD  RO  reads 0; writes ignored
//   2 MASK  RW  irqmask[WIDTH-1:0]; upper bits read 0
//   3 EDGE  RW1C edgecapture[WIDTH-1:0]; writing 1 clears that bit
//  readdata is updated every cycle from address, so read latency is 1 cycle and there are no wait states.
//  A write is chipselect & ~write_n; it takes effect on the next edge.
//  Synchroniser: 2 flops per bit -> sync.
//  Prescaler: counts 0..TICK_DIV-1; tick pulses for 1 cycle on wrap.
//  Debounce, per bit:
//   - if sync==stable, cnt is cleared;
//   - else on each tick cnt increments;
//   - when cnt reaches STABLE_TICKS-1 with a tick, stable<=sync and cnt is cleared.
//   - A glitch shorter than STABLE_TICKS ticks never reaches stable.
//  FSM:
//   - S_SYNC: waits 2 cycles, then loads stable<=sync with edge detection suppressed, then goes to S_RUN.
//   - S_RUN: normal operation. Reset from any state returns to S_SYNC.
//   - Consequence: a switch already high at reset produces no edge.
//  Edge: a change of stable qualified by EDGE_TYPE sets edgecapture[i].
//  Same-cycle set and W1C on the same bit: the set wins and the bit stays 1.
//  irq = |(edgecapture & irqmask), driven from registers (glitch-free).
//  Writing MASK to unmask an already-captured edge asserts irq on the next cycle.
//  Worst-case in_port->DATA latency: 2 + 1 + TICK_DIV*STABLE_TICKS cycles.
// CONFIGURATION
//  NIOS_SWITCH_DEBOUNCE_EN defined:
//   - prescaler and per-bit counters are present, as described above.
//  NIOS_SWITCH_DEBOUNCE_EN undefined:
//   - stable<=sync every cycle in S_RUN; no prescaler or counters are built.
//   - TICK_DIV and STABLE_TICKS are ignored.
//   - in_port->DATA latency is 3 cycles.
// STRUCTURE
//  Package nios_switch_pkg holds:
//   - address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_MASK=2, ADDR_EDGE=3;
//   - edge-type constants EDGE_RISE/EDGE_FALL/EDGE_ANY;
//   - FSM state enum {S_SYNC, S_RUN}.
//  Sub-module nios_switch_debounce: one line per instance.
//   - Inputs: clk, reset, tick, sync_in, load.
//   - Output: stable_out.
//   - Generated WIDTH times.
//   - Compiles to a pass-through register without NIOS_SWITCH_DEBOUNCE_EN.
//  Top level holds: synchroniser, prescaler, FSM, edge detect, registers, read mux.
// TESTING
//  Directed scenarios below use TICK_DIV=4, STABLE_TICKS=3, WIDTH=10, with NIOS_SWITCH_DEBOUNCE_EN defined.
//  1 Reset check: hold reset 3 cycles with in_port=10'h3FF, then release.
//    -> read 0 returns 0x3FF after settling; read 3 returns 0; irq=0 throughout.
//  2 Glitch rejection: in_port[0] 0->1 for 8 cycles, then back to 0.
//    -> DATA stays 0x000; EDGE stays 0.
//  3 Rising edge with irq: EDGE_TYPE=2, MASK=0x001, in_port[0]=1 held for 20 cycles.
//    -> within 15 cycles DATA[0]=1, EDGE=0x001 and irq=1.
//    -> write 0x001 to addr 3: EDGE=0 and irq=0 one cycle later.
//  4 Set/clear collision: force an edge on bit 2 in the same cycle as a W1C of 0x004.
//    -> EDGE[2]=1 and irq stays asserted if bit 2 is masked.
//  5 Late unmask: with MASK=0, capture edges on bits 3 and 5 (EDGE=0x028, irq=0).
//    -> write MASK=0x020: irq=1 the next cycle; RSVD reads 0; upper readdata bits read 0.
//  6 Mid-operation reset: assert reset while a bit's counter is partway through debouncing.
//    -> all counters, EDGE and MASK return to 0; the FSM re-enters S_SYNC; no spurious edge afterwards.

Source files
------------

// File: rtl/nios_switch_pkg.sv
// Shared definitions for the Nios II slide-switch controller:
// register map, edge-mode selectors and the start-up FSM states.
package nios_switch_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_RSVD = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   typedef enum logic {
      S_SYNC = 1'b0,
      S_RUN  = 1'b1
   } sw_state_e;

   // True when a prev->cur transition matches the selected edge mode.
   function automatic logic edge_hit(input int edge_type, input logic prev, input logic cur);
      case (edge_type)
         EDGE_RISE: edge_hit = cur & ~prev;
         EDGE_FALL: edge_hit = ~cur & prev;
         default:   edge_hit = cur ^ prev;
      endcase
   endfunction

endpackage

// File: rtl/nios_switch_debounce.sv
// Debounce filter for one synchronised switch line.
// With NIOS_SWITCH_DEBOUNCE_EN undefined it collapses to a single pass-through flop.
module nios_switch_debounce
   import nios_switch_pkg::*;
#(
   parameter int STABLE_TICKS = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic sync_in,
   input  logic load,
   output logic stable_out
);

`ifdef NIOS_SWITCH_DEBOUNCE_EN
   localparam logic [7:0] CNT_LAST = 8'(STABLE_TICKS - 1);

   logic [7:0] cnt;

   // Any return to the accepted level restarts the qualification window.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         stable_out <= 1'b0;
      end else if (load) begin
         stable_out <= sync_in;
         cnt        <= '0;
      end else if (sync_in == stable_out) begin
         cnt <= '0;
      end else if (tick) begin
         if (cnt == CNT_LAST) begin
            stable_out <= sync_in;
            cnt        <= '0;
         end else begin
            cnt <= cnt + 8'd1;
         end
      end
   end
`else
   localparam int unused_stable_ticks = STABLE_TICKS;

   logic unused_ctrl;
   assign unused_ctrl = tick ^ load;

   always_ff @(posedge clk) begin
      if (reset) begin
         stable_out <= 1'b0;
      end else begin
         stable_out <= sync_in;
      end
   end
`endif

endmodule

// File: rtl/nios_led2_switch_ctrl.sv
// Avalon-MM slide-switch controller: sync, debounce, edge capture (W1C) and maskable irq.
// Debounce prescaler/counters are built only when NIOS_SWITCH_DEBOUNCE_EN is defined.
module nios_led2_switch_ctrl
   import nios_switch_pkg::*;
#(
   parameter int WIDTH        = 10,
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 8,
   parameter int EDGE_TYPE    = EDGE_ANY
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   // FSM states
   //   state  | meaning
   //   S_SYNC | let the synchroniser fill, then load stable directly (no edges)
   //   S_RUN  | normal debounce and edge capture

   logic [WIDTH-1:0] sync_meta;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_prev;
   logic [WIDTH-1:0] edge_evt;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] irqmask_nxt;
   logic [WIDTH-1:0] edgecap;
   logic [WIDTH-1:0] edgecap_nxt;
   logic [31:0]      rd_nxt;
   logic             tick;
   logic             tick_run;
   logic             load;
   logic             run_q;
   logic             wr_en;
   logic [1:0]       wait_cnt;
   logic [1:0]       wait_nxt;
   sw_state_e        state;
   sw_state_e        state_nxt;
   logic             unused_wdata;

   assign unused_wdata = ^writedata;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta <= '0;
         sync_q    <= '0;
      end else begin
         sync_meta <= in_port;
         sync_q    <= sync_meta;
      end
   end

`ifdef NIOS_SWITCH_DEBOUNCE_EN
   localparam int              PRE_W    = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0] prescaler;

   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler <= '0;
      end else if (prescaler == PRE_LAST) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + PRE_W'(1);
      end
   end

   assign tick = (prescaler == PRE_LAST);
`else
   localparam int unused_tick_div = TICK_DIV;

   assign tick = 1'b0;
`endif

   // Counters only advance once the initial load has been taken.
   assign tick_run = tick & (state == S_RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_SYNC;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      load      = 1'b0;
      case (state)
         S_SYNC: begin
            if (wait_cnt == 2'd2) begin
               load      = 1'b1;
               wait_nxt  = '0;
               state_nxt = S_RUN;
            end else begin
               wait_nxt = wait_cnt + 2'd1;
            end
         end
         S_RUN: begin
            state_nxt = S_RUN;
         end
         default: begin
            state_nxt = S_SYNC;
         end
      endcase
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_line
      nios_switch_debounce #(
         .STABLE_TICKS (STABLE_TICKS)
      ) u_deb (
         .clk        (clk),
         .reset      (reset),
         .tick       (tick_run),
         .sync_in    (sync_q[i]),
         .load       (load),
         .stable_out (stable[i])
      );
   end

   // run_q lags the state by one cycle so the change caused by the load is not seen as an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable_prev <= '0;
         run_q       <= 1'b0;
      end else begin
         stable_prev <= stable;
         run_q       <= (state == S_RUN);
      end
   end

   always_comb begin
      edge_evt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         edge_evt[i] = run_q & edge_hit(EDGE_TYPE, stable_prev[i], stable[i]);
      end
   end

   assign wr_en = chipselect & ~write_n;

   // A new edge is OR-ed in after the clear, so it survives a same-cycle W1C.
   always_comb begin
      irqmask_nxt = irqmask;
      edgecap_nxt = edgecap;
      if (wr_en && (address == ADDR_MASK)) begin
         irqmask_nxt = writedata[WIDTH-1:0];
      end
      if (wr_en && (address == ADDR_EDGE)) begin
         edgecap_nxt = edgecap & ~writedata[WIDTH-1:0];
      end
      edgecap_nxt = edgecap_nxt | edge_evt;
   end

   always_comb begin
      rd_nxt = '0;
      case (address)
         ADDR_DATA: rd_nxt[WIDTH-1:0] = stable;
         ADDR_MASK: rd_nxt[WIDTH-1:0] = irqmask;
         ADDR_EDGE: rd_nxt[WIDTH-1:0] = edgecap;
         default:   rd_nxt = '0;
      endcase
   end

   // irq is computed from next-state values so it is a clean flop output with no extra lag.
   always_ff @(posedge clk) begin
      if (reset) begin
         irqmask  <= '0;
         edgecap  <= '0;
         irq      <= 1'b0;
         readdata <= '0;
      end else begin
         irqmask  <= irqmask_nxt;
         edgecap  <= edgecap_nxt;
         irq      <= |(edgecap_nxt & irqmask_nxt);
         readdata <= rd_nxt;
      end
   end

endmodule

// File: tb/tb_nios_led2_switch_ctrl.sv
// Self-checking bench for nios_led2_switch_ctrl against a level/edge reference model.
// Follows NIOS_SWITCH_DEBOUNCE_EN as defined for the build.
module tb_nios_led2_switch_ctrl;

   localparam int WIDTH        = 10;
   localparam int TICK_DIV     = 4;
   localparam int STABLE_TICKS = 3;
   localparam int EDGE_TYPE    = 2;
`ifdef NIOS_SWITCH_DEBOUNCE_EN
   localparam bit DEB = 1'b1;
`else
   localparam bit DEB = 1'b0;
`endif
   localparam int GLITCH_MAX = TICK_DIV * (STABLE_TICKS - 1);
   localparam int SETTLE     = TICK_DIV * STABLE_TICKS + 8;

   logic             clk;
   logic             reset;
   logic [1:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [31:0]      writedata;
   logic [31:0]      readdata;
   logic [WIDTH-1:0] in_port;
   logic             irq;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [WIDTH-1:0] m_stable;
   logic [WIDTH-1:0] m_edge;
   logic [WIDTH-1:0] m_mask;

   nios_led2_switch_ctrl #(
      .WIDTH        (WIDTH),
      .TICK_DIV     (TICK_DIV),
      .STABLE_TICKS (STABLE_TICKS),
      .EDGE_TYPE    (EDGE_TYPE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycles since reset release; the debounce tick lands on multiples of TICK_DIV.
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   function automatic logic [WIDTH-1:0] qual(input logic [WIDTH-1:0] prev, input logic [WIDTH-1:0] cur);
      case (EDGE_TYPE)
         0:       return cur & ~prev;
         1:       return ~cur & prev;
         default: return cur ^ prev;
      endcase
   endfunction

   task automatic accept_level(input logic [WIDTH-1:0] lvl);
      m_edge   = m_edge | qual(m_stable, lvl);
      m_stable = lvl;
   endtask

   task automatic hold(input logic [WIDTH-1:0] v, input int n);
      @(negedge clk);
      in_port = v;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a;
      @(posedge clk);
      #1;
      d = readdata;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      reset = 1'b1;
      in_port = 10'h3FF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (readdata !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: readdata=%h irq=%b expected 0/0", readdata, irq);
         end
      end
      reset = 1'b0;
      m_stable = 10'h3FF;
      m_edge   = '0;
      m_mask   = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b expected 0", irq);
         end
      end
      reg_read(2'd0, rd);
      checks++;
      if (rd !== 32'(m_stable)) begin
         errors++;
         $display("FAIL reset_data: got %h expected %h", rd, 32'(m_stable));
      end
      reg_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL reset_edge: got %h expected 0", rd);
      end
      hold('0, SETTLE);
      accept_level('0);
      reg_read(2'd3, rd);
      checks++;
      if (rd !== 32'(m_edge)) begin
         errors++;
         $display("FAIL fall_all_edge: got %h expected %h", rd, 32'(m_edge));
      end
      reg_write(2'd3, 32'h3FF);
      m_edge = '0;
      reg_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL w1c_all: got %h expected 0", rd);
      end
   endtask

   task automatic test_glitch();
      logic [31:0]      rd;
      logic [WIDTH-1:0] base;
      logic [WIDTH-1:0] g;
      base = m_stable;
      g    = base ^ 10'h001;
      hold(g, 8);
      hold(base, SETTLE);
      if (!DEB) begin
         accept_level(g);
         accept_level(base);
      end
      reg_read(2'd0, rd);
      checks++;
      if (rd !== 32'(m_stable)) begin
         errors++;
         $display("FAIL glitch_data: got %h expected %h", rd, 32'(m_stable));
      end
      reg_read(2'd3, rd);
      checks++;
      if (rd !== 32'(m_edge)) begin
         errors++;
         $display("FAIL glitch_edge: got %h expected %h", rd, 32'(m_edge));
      end
      reg_write(2'd3, 32'h3FF);
      m_edge = '0;
   endtask

   task automatic test_rise_irq();
      logic [31:0] rd;
      reg_write(2'd2, 32'h001);
      m_mask = 10'h001;
      hold(m_stable | 10'h001, 16);
      accept_level(m_stable | 10'h001);
      checks++;
      if (irq !== (|(m_edge & m_mask))) begin
         errors++;
         $display("FAIL rise_irq: got %b expected %b", irq, |(m_edge & m_mask));
      end
      reg_read(2'd0, rd);
      checks++;
      if (rd !== 32'(m_stable)) begin
         errors++;
         $display("FAIL rise_data: got %h expected %h", rd, 32'(m_stable));
      end
      reg_read(2'd3, rd);
      checks++;
      if (rd !== 32'(m_edge)) begin
         errors++;
         $display("FAIL rise_edge: got %h expected %h", rd, 32'(m_edge));
      end
      reg_write(2'd3, 32'h001);
      m_edge = m_edge & ~10'h001;
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL w1c_irq: got %b expected 0", irq);
      end
      reg_read(2'd3, rd);
      checks++;
      if (rd !== 32'(m_edge)) begin
         errors++;
         $display("FAIL w1c_edge: got %h expected %h", rd, 32'(m_edge));
      end
   endtask

   task automatic test_collision();
      logic [31:0] rd;
      int a;
      int m1;
      int set_cyc;
      reg_write(2'd2, 32'h004);
      m_mask = 10'h004;
      @(negedge clk);
      a = cyc;
      in_port = m_stable ^ 10'h004;
      if (DEB) begin
         m1 = a + 3;
         while (m1 % TICK_DIV != 0) m1++;
         set_cyc = m1 + TICK_DIV * (STABLE_TICKS - 1) + 1;
      end else begin
         set_cyc = a + 4;
      end
      while (cyc < set_cyc - 1) @(negedge clk);
      address    = 2'd3;
      writedata  = 32'h004;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      accept_level(m_stable ^ 10'h004);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL collision_irq: got %b expected 1", irq);
      end
      reg_read(2'd3, rd);
      checks++;
      if (rd !== 32'(m_edge)) begin
         errors++;
         $display("FAIL collision_edge: got %h expected %h", rd, 32'(m_edge));
      end
      reg_write(2'd3, 32'h004);
      m_edge = m_edge & ~10'h004;
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL collision_clear_irq: got %b expected 0", irq);
      end
   endtask

   task automatic test_late_unmask();
      logic [31:0] rd;
      reg_write(2'd2, 32'h0);
      m_mask = '0;
      hold(m_stable ^ 10'h028, SETTLE);
      accept_level(m_stable ^ 10'h028);
      reg_read(2'd3, rd);
      checks++;
      if (rd !== 32'(m_edge)) begin
         errors++;
         $display("FAIL late_edge: got %h expected %h", rd, 32'(m_edge));
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL late_irq_masked: got %b expected 0", irq);
      end
      reg_write(2'd2, 32'hFFFF_FC20);
      m_mask = 10'h020;
      checks++;
      if (irq !== (|(m_edge & m_mask))) begin
         errors++;
         $display("FAIL late_unmask_irq: got %b expected %b", irq, |(m_edge & m_mask));
      end
      reg_write(2'd1, 32'hFFFF_FFFF);
      reg_read(2'd1, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL rsvd_read: got %h expected 0", rd);
      end
      reg_read(2'd2, rd);
      checks++;
      if (rd !== 32'(m_mask)) begin
         errors++;
         $display("FAIL mask_read: got %h expected %h", rd, 32'(m_mask));
      end
      reg_read(2'd0, rd);
      checks++;
      if (rd !== 32'(m_stable)) begin
         errors++;
         $display("FAIL data_upper: got %h expected %h", rd, 32'(m_stable));
      end
      reg_write(2'd3, 32'h3FF);
      m_edge = '0;
   endtask

   task automatic test_back_to_back();
      logic [31:0]      rd;
      logic [WIDTH-1:0] base;
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] lvl;
      logic [WIDTH-1:0] w;
      int               d;
      for (int it = 0; it < 24; it++) begin
         base = m_stable;
         g    = base ^ WIDTH'($urandom_range(1, 1023));
         lvl  = WIDTH'($urandom_range(0, 1023));
         d    = $urandom_range(1, GLITCH_MAX);
         hold(g, d);
         hold(base, 4);
         hold(lvl, SETTLE);
         if (!DEB) begin
            accept_level(g);
            accept_level(base);
         end
         accept_level(lvl);
         reg_read(2'd0, rd);
         checks++;
         if (rd !== 32'(m_stable)) begin
            errors++;
            $display("FAIL rand_data[%0d]: got %h expected %h", it, rd, 32'(m_stable));
         end
         reg_read(2'd3, rd);
         checks++;
         if (rd !== 32'(m_edge)) begin
            errors++;
            $display("FAIL rand_edge[%0d]: got %h expected %h", it, rd, 32'(m_edge));
         end
         w = WIDTH'($urandom_range(0, 1023));
         reg_write(2'd2, 32'(w));
         m_mask = w;
         checks++;
         if (irq !== (|(m_edge & m_mask))) begin
            errors++;
            $display("FAIL rand_mask_irq[%0d]: got %b expected %b", it, irq, |(m_edge & m_mask));
         end
         w = WIDTH'($urandom_range(0, 1023));
         reg_write(2'd3, 32'(w));
         m_edge = m_edge & ~w;
         checks++;
         if (irq !== (|(m_edge & m_mask))) begin
            errors++;
            $display("FAIL rand_w1c_irq[%0d]: got %b expected %b", it, irq, |(m_edge & m_mask));
         end
      end
      reg_read(2'd3, rd);
      checks++;
      if (rd !== 32'(m_edge)) begin
         errors++;
         $display("FAIL rand_final_edge: got %h expected %h", rd, 32'(m_edge));
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0]      rd;
      logic [WIDTH-1:0] lvl;
      reg_write(2'd3, 32'h3FF);
      m_edge = '0;
      reg_write(2'd2, 32'h080);
      m_mask = 10'h080;
      hold(m_stable ^ 10'h080, SETTLE);
      accept_level(m_stable ^ 10'h080);
      checks++;
      if (irq !== (|(m_edge & m_mask))) begin
         errors++;
         $display("FAIL pre_reset_irq: got %b expected %b", irq, |(m_edge & m_mask));
      end
      lvl = m_stable ^ 10'h002;
      hold(lvl, 6);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (readdata !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: readdata=%h irq=%b expected 0/0", readdata, irq);
         end
      end
      reset = 1'b0;
      m_stable = lvl;
      m_edge   = '0;
      m_mask   = '0;
      for (int i = 0; i < SETTLE; i++) begin
         @(negedge clk);
         checks++;
         if (irq !== 1'b0) begin
            errors++;
            $display("FAIL midreset_irq: got %b expected 0", irq);
         end
      end
      reg_read(2'd0, rd);
      checks++;
      if (rd !== 32'(m_stable)) begin
         errors++;
         $display("FAIL midreset_data: got %h expected %h", rd, 32'(m_stable));
      end
      reg_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL midreset_edge: got %h expected 0", rd);
      end
      reg_read(2'd2, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL midreset_mask: got %h expected 0", rd);
      end
   endtask

   initial begin
      reset      = 1'b1;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = 10'h3FF;
      m_stable   = '0;
      m_edge     = '0;
      m_mask     = '0;
      test_reset();
      test_glitch();
      test_rise_irq();
      test_collision();
      test_late_unmask();
      test_back_to_back();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
